// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch unit.
// Issues in-order word reads to instruction memory under a credit limit of QDEPTH,
// tags each response with its PC from a small PC FIFO, and buffers instructions in a
// QDEPTH-entry queue presented to decode with a valid/ready handshake. A redirect
// (is_jump) flushes the queue and discards every response still in flight.
// Optional feature: define FETCH_MISALIGN_CHECK_EN to flag misaligned redirect targets
// (misalign=1) and halt fetching until the next aligned redirect.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        is_jump,
  input  logic [31:0] jump_target,
  output logic        misalign
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int SW = CW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;     // instructions held in the queue
  logic [CW-1:0] outst_q, outst_d;     // requests accepted but not yet answered
  logic [CW-1:0] drop_q, drop_d;       // responses still to be discarded after a redirect
  logic [PW-1:0] qrd_q, qrd_d, qwr_q, qwr_d;
  logic [PW-1:0] prd_q, prd_d, pwr_q, pwr_d;

  logic [31:0]   q_data_q [QDEPTH];
  logic [31:0]   q_pc_q   [QDEPTH];
  logic [31:0]   pc_fifo_q[QDEPTH];

  logic [SW-1:0] inflight;
  logic          halted;
  logic          req_fire;
  logic          push;
  logic          pop;

  assign inflight       = {1'b0, count_q} + {1'b0, outst_q};
  assign imem_req_valid = !rst && !is_jump && !halted && (inflight < SW'(QDEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response is kept only when no redirect is active this cycle and no drops remain.
  assign push = imem_resp_valid && !is_jump && (drop_q == '0);
  // A redirect wins over decode: the head is flushed, not consumed.
  assign pop  = inst_valid && inst_ready && !is_jump;

  assign inst_valid = !rst && (count_q != '0);
  assign inst       = inst_valid ? q_data_q[qrd_q] : '0;
  assign inst_pc    = inst_valid ? q_pc_q[qrd_q]   : '0;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic halted_q, halted_d;
  logic target_misaligned;

  assign target_misaligned = (jump_target[1:0] != 2'b00);
  assign halted_d          = is_jump ? target_misaligned : halted_q;

  // Misaligned redirect parks fetch (and raises misalign) until an aligned redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign halted   = halted_q;
  assign misalign = halted_q;
`else
  assign halted   = 1'b0;
  assign misalign = 1'b0;
`endif

  // Next-state for fetch PC, credit counters, queue and PC-FIFO pointers.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    drop_d     = drop_q;
    qrd_d      = qrd_q;
    qwr_d      = qwr_q;
    prd_d      = prd_q;
    pwr_d      = pwr_q;
    outst_d    = outst_q + CW'(req_fire) - CW'(imem_resp_valid);

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      pwr_d      = pwr_q + PW'(1);
    end
    // Every response, kept or dropped, retires its PC-FIFO entry.
    if (imem_resp_valid) begin
      prd_d = prd_q + PW'(1);
    end

    if (is_jump) begin
      fetch_pc_d = jump_target & ~32'h3;
      count_d    = '0;
      qrd_d      = qwr_q;
      drop_d     = outst_d;
    end else begin
      if (push) begin
        qwr_d = qwr_q + PW'(1);
      end
      if (pop) begin
        qrd_d = qrd_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      if (imem_resp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      qrd_q      <= '0;
      qwr_q      <= '0;
      prd_q      <= '0;
      pwr_q      <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      qrd_q      <= qrd_d;
      qwr_q      <= qwr_d;
      prd_q      <= prd_d;
      pwr_q      <= pwr_d;
    end
  end

  // Payload storage: PC of each issued request, and {data, pc} of each kept response.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are not reset; count/pointers define validity and outputs are gated.
    if (req_fire) begin
      pc_fifo_q[pwr_q] <= fetch_pc_q;
    end
    if (push) begin
      q_data_q[qwr_q] <= imem_resp_data;
      q_pc_q[qwr_q]   <= pc_fifo_q[prd_q];
    end
  end

  // Memory may only answer issued requests; queue plus in-flight stays within credit.
  assert property (@(posedge clk) disable iff (rst) imem_resp_valid |-> (outst_q != '0));
  assert property (@(posedge clk) disable iff (rst) inflight <= SW'(QDEPTH));

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: self-checking bench for inst_fetch.
// A behavioural memory answers requests in order (latency >= 1, optionally held back).
// A scoreboard predicts request addresses, the credit-limited request valid, and the
// instruction/PC stream seen by decode; redirects mark in-flight responses stale.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QDEPTH   = 2;
  localparam logic [31:0] KEY      = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        is_jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        misalign;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .is_jump        (is_jump),
    .jump_target    (jump_target),
    .misalign       (misalign)
  );

  typedef struct { logic [31:0] addr; int cyc; bit stale; } pend_t;
  typedef struct { logic [31:0] data; logic [31:0] pc; } exp_t;
  typedef struct { logic [31:0] tgt; logic [31:0] pc0; logic [31:0] pc1; } jvec_t;

  pend_t       pend[$];      // requests accepted by memory, oldest first
  exp_t        exp_q[$];     // predicted decode queue contents
  logic [31:0] popped[$];    // PCs consumed by decode
  logic [31:0] fire_log[$];  // addresses of accepted requests
  jvec_t       jtab[$];

  logic [31:0] exp_pc;
  bit          exp_halted;
  bit          mem_hold;
  int          cyc_cnt;
  int          n_fires;
  int          n_checks;
  int          n_errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] pop_at(input int idx);
    return (popped.size() > idx) ? popped[idx] : 'x;
  endfunction

  function automatic logic [31:0] fire_at(input int idx);
    return (fire_log.size() > idx) ? fire_log[idx] : 'x;
  endfunction

  // One clock cycle, entered and left at the falling edge.
  task automatic cycle(input bit jmp, input logic [31:0] tgt);
    bit   resp_now;
    bit   exp_req;
    exp_t e;
    is_jump     = jmp;
    jump_target = tgt;
    resp_now    = !mem_hold && (pend.size() > 0) && (pend[0].cyc < cyc_cnt);
    imem_resp_valid = resp_now;
    imem_resp_data  = resp_now ? (pend[0].addr ^ KEY) : 32'h0;
    #1;
    check("inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
    if (inst_valid && exp_q.size() != 0) begin
      check("inst", inst, exp_q[0].data);
      check("inst_pc", inst_pc, exp_q[0].pc);
    end
    exp_req = !jmp && !exp_halted && ((exp_q.size() + pend.size()) < QDEPTH);
    check("req_valid", 32'(imem_req_valid), 32'(exp_req));
`ifdef FETCH_MISALIGN_CHECK_EN
    check("misalign", 32'(misalign), 32'(exp_halted));
`else
    check("misalign", 32'(misalign), 32'h0);
`endif
    if (jmp) begin
      exp_q.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      exp_pc = tgt & ~32'h3;
`ifdef FETCH_MISALIGN_CHECK_EN
      exp_halted = (tgt[1:0] != 2'b00);
`endif
    end else if (inst_valid && inst_ready && exp_q.size() != 0) begin
      popped.push_back(exp_q[0].pc);
      void'(exp_q.pop_front());
    end
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, exp_pc);
      fire_log.push_back(imem_req_addr);
      pend.push_back('{addr: imem_req_addr, cyc: cyc_cnt, stale: 1'b0});
      exp_pc = exp_pc + 32'd4;
      n_fires++;
    end
    if (resp_now) begin
      if (!pend[0].stale) begin
        e.data = pend[0].addr ^ KEY;
        e.pc   = pend[0].addr;
        exp_q.push_back(e);
      end
      void'(pend.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    cyc_cnt++;
    is_jump = 1'b0;
    imem_resp_valid = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) cycle(1'b0, 32'h0);
  endtask

  // Reset DUT and memory model together, then check the reset outputs.
  task automatic do_reset(input int n);
    rst = 1'b1;
    is_jump = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      cyc_cnt++;
    end
    check("rst_inst_valid", 32'(inst_valid), 32'h0);
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_misalign", 32'(misalign), 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    pend.delete();
    exp_q.delete();
    exp_pc     = RESET_PC;
    exp_halted = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    n_checks = 0;
    n_errors = 0;
    cyc_cnt  = 0;
    mem_hold = 1'b0;
    exp_pc   = RESET_PC;

    jtab.push_back('{tgt: 32'h0000_1000, pc0: 32'h0000_1000, pc1: 32'h0000_1004});
    jtab.push_back('{tgt: 32'hFFFF_FFF8, pc0: 32'hFFFF_FFF8, pc1: 32'hFFFF_FFFC});
    jtab.push_back('{tgt: 32'hFFFF_FFFC, pc0: 32'hFFFF_FFFC, pc1: 32'h0000_0000});
    jtab.push_back('{tgt: 32'h0000_0080, pc0: 32'h0000_0080, pc1: 32'h0000_0084});
`ifndef FETCH_MISALIGN_CHECK_EN
    jtab.push_back('{tgt: 32'h0000_0103, pc0: 32'h0000_0100, pc1: 32'h0000_0104});
`endif

    // Basic in-order fetch after a 2-cycle reset.
    do_reset(2);
    inst_ready = 1'b1;
    popped.delete();
    fire_log.delete();
    run(12);
    check("first_req_addr", fire_at(0), 32'h0);
    check("seq_pc0", pop_at(0), 32'h0);
    check("seq_pc1", pop_at(1), 32'h4);
    check("seq_pc2", pop_at(2), 32'h8);

    // Decode stall: credit caps requests at QDEPTH, then resume without loss.
    do_reset(2);
    inst_ready = 1'b0;
    n_fires = 0;
    run(10);
    check("stall_fires", 32'(n_fires), 32'(QDEPTH));
    check("stall_req_valid", 32'(imem_req_valid), 32'h0);
    inst_ready = 1'b1;
    popped.delete();
    fire_log.delete();
    run(12);
    check("resume_addr", fire_at(0), 32'h8);
    check("resume_pc0", pop_at(0), 32'h0);
    check("resume_pc1", pop_at(1), 32'h4);
    check("resume_pc2", pop_at(2), 32'h8);
    check("resume_pc3", pop_at(3), 32'hC);

    // Two outstanding responses, redirect, both must be dropped.
    mem_hold = 1'b1;
    run(4);
    check("hold_req_valid", 32'(imem_req_valid), 32'h0);
    cycle(1'b1, 32'h0000_0100);
    mem_hold = 1'b0;
    popped.delete();
    fire_log.delete();
    run(12);
    check("drop_next_addr", fire_at(0), 32'h100);
    check("drop_next_pc", pop_at(0), 32'h100);

    // Redirect in the same cycle as a response and a decode pop.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (inst_valid && pend.size() > 0 && pend[0].cyc < cyc_cnt) found = 1'b1;
      else run(1);
    end
    check("collision_found", 32'(found), 32'h1);
    cycle(1'b1, 32'h0000_0300);
    check("collision_flush", 32'(inst_valid), 32'h0);
    popped.delete();
    run(10);
    check("collision_next_pc", pop_at(0), 32'h300);

    // Redirect table, including the top-of-memory wrap.
    for (int i = 0; i < jtab.size(); i++) begin
      cycle(1'b1, jtab[i].tgt);
      check("jtab_flush", 32'(inst_valid), 32'h0);
      popped.delete();
      run(10);
      check("jtab_pc0", pop_at(0), jtab[i].pc0);
      check("jtab_pc1", pop_at(1), jtab[i].pc1);
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned redirect halts fetch; aligned redirect recovers.
    cycle(1'b1, 32'h0000_0102);
    check("mis_set", 32'(misalign), 32'h1);
    n_fires = 0;
    run(8);
    check("mis_no_fires", 32'(n_fires), 32'h0);
    cycle(1'b1, 32'h0000_0200);
    check("mis_clear", 32'(misalign), 32'h0);
    popped.delete();
    run(10);
    check("mis_recover_pc", pop_at(0), 32'h200);
`endif

    // Random traffic: back-pressure on both sides, held responses, frequent redirects.
    for (int i = 0; i < 300; i++) begin
      inst_ready     = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      mem_hold       = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 15) == 0) cycle(1'b1, $urandom & 32'hFFFF_FFFC);
      else run(1);
    end
    inst_ready     = 1'b1;
    imem_req_ready = 1'b1;
    mem_hold       = 1'b0;
    run(6);

    // Reset in the middle of a running stream.
    do_reset(2);
    popped.delete();
    run(10);
    check("post_rst_pc", pop_at(0), RESET_PC);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
